// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: 8x16 register file, sequential A/B operand reads, valid/ready hand-off to the shifter.
// Build option: define OPERAND_BYPASS_EN to forward a same-cycle register write into the operand being read.
module operand_fetch_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rn,
    input  logic [AW-1:0]     rm,
    input  logic [1:0]        shift_in,
    input  logic              w_en,
    input  logic [AW-1:0]     w_num,
    input  logic [DATA_W-1:0] w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [1:0]        shift_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        VALID  = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [AW-1:0]                rn_q, rn_d;
    logic [AW-1:0]                rm_q, rm_d;
    logic [1:0]                   req_shift_q, req_shift_d;
    logic [DATA_W-1:0]            a_q, a_d;
    logic [DATA_W-1:0]            b_q, b_d;
    logic [1:0]                   shift_out_q, shift_out_d;
    logic                         out_valid_q, out_valid_d;
    logic [DATA_W-1:0]            rd_a_c, rd_b_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk, holding in VALID under backpressure
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = READ_A;
            READ_A:  state_d = READ_B;
            READ_B:  state_d = VALID;
            VALID:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register-file read ports; the forwarding path exists only in the bypass build
    always_comb begin
        rd_a_c = regs_q[rn_q];
        rd_b_c = regs_q[rm_q];
`ifdef OPERAND_BYPASS_EN
        if (w_en && (w_num == rn_q)) rd_a_c = w_data;
        if (w_en && (w_num == rm_q)) rd_b_c = w_data;
`endif
    end

    // Output / datapath logic driven by the current state
    always_comb begin
        rn_d        = rn_q;
        rm_d        = rm_q;
        req_shift_d = req_shift_q;
        a_d         = a_q;
        b_d         = b_q;
        shift_out_d = shift_out_q;
        out_valid_d = (state_d == VALID);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rn_d        = rn;
                    rm_d        = rm;
                    req_shift_d = shift_in;
                end
            end
            READ_A: a_d = rd_a_c;
            READ_B: begin
                b_d         = rd_b_c;
                shift_out_d = req_shift_q;
            end
            default: ;
        endcase
    end

    // Register-file write port, legal in every state
    always_comb begin
        regs_d = regs_q;
        if (w_en) regs_d[w_num] = w_data;
    end

    // Datapath flops; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            req_shift_q <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            shift_out_q <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            req_shift_q <= req_shift_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shift_out_q <= shift_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign shift_out = shift_out_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage; expectations follow OPERAND_BYPASS_EN when defined.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift_in;
    logic        w_en;
    logic [2:0]  w_num;
    logic [15:0] w_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [1:0]  shift_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef OPERAND_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    operand_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rn        (rn),
        .rm        (rm),
        .shift_in  (shift_in),
        .w_en      (w_en),
        .w_num     (w_num),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .shift_out (shift_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [2:0] num, input logic [15:0] data);
        w_en = 1'b1; w_num = num; w_data = data;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    // Issue one request from IDLE and return at the first negedge with out_valid high.
    // wphase 1 = write during READ_A, 2 = write during READ_B, 0 = no write.
    task automatic issue(input string tag, input logic [2:0] rn_i, input logic [2:0] rm_i,
                         input logic [1:0] sh_i, input int wphase,
                         input logic [2:0] wn, input logic [15:0] wd);
        int lat;
        check_eq({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        rn = rn_i; rm = rm_i; shift_in = sh_i; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            if (lat == wphase) begin
                w_en = 1'b1; w_num = wn; w_data = wd;
            end
            @(negedge clk);
            w_en = 1'b0;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_valid_post"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; rn = '0; rm = '0; shift_in = '0;
        w_en = 1'b0; w_num = '0; w_data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_a", 32'(a_out), 32'h0);
        check_eq("rst_b", 32'(b_out), 32'h0);
        check_eq("rst_shift", 32'(shift_out), 32'h0);

        write_reg(3'd3, 16'h00F0);
        write_reg(3'd5, 16'h8001);
        write_reg(3'd2, 16'h0007);
        write_reg(3'd4, 16'hAAAA);
        write_reg(3'd6, 16'h1111);

        // Basic fetch with immediate acceptance
        out_ready = 1'b1;
        issue("basic", 3'd3, 3'd5, 2'b11, 0, 3'd0, 16'h0);
        check_eq("basic_in_ready", 32'(in_ready), 32'd0);
        check_eq("basic_a", 32'(a_out), 32'h00F0);
        check_eq("basic_b", 32'(b_out), 32'h8001);
        check_eq("basic_shift", 32'(shift_out), 32'h3);
        handshake("basic");

        // Backpressure with an ignored request and a snapshot-violating write
        out_ready = 1'b0;
        issue("bp", 3'd3, 3'd5, 2'b11, 0, 3'd0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                in_valid = 1'b1; rn = 3'd0; rm = 3'd0; shift_in = 2'b01;
            end
            if (i == 2) begin
                w_en = 1'b1; w_num = 3'd5; w_data = 16'h1234;
            end
            @(negedge clk);
            w_en = 1'b0;
            check_eq($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            check_eq($sformatf("bp_a_%0d", i), 32'(a_out), 32'h00F0);
            check_eq($sformatf("bp_b_%0d", i), 32'(b_out), 32'h8001);
            check_eq($sformatf("bp_shift_%0d", i), 32'(shift_out), 32'h3);
        end
        in_valid = 1'b0;
        handshake("bp");

        // The write made during VALID is visible to the next request
        issue("snap", 3'd0, 3'd5, 2'b01, 0, 3'd0, 16'h0);
        check_eq("snap_a", 32'(a_out), 32'h0000);
        check_eq("snap_b", 32'(b_out), 32'h1234);
        check_eq("snap_shift", 32'(shift_out), 32'h1);
        handshake("snap");

        // Same-cycle write during READ_B of rm=2
        issue("hzb", 3'd0, 3'd2, 2'b10, 2, 3'd2, 16'hBEEF);
        check_eq("hzb_b", 32'(b_out), BYPASS ? 32'hBEEF : 32'h0007);
        check_eq("hzb_shift", 32'(shift_out), 32'h2);
        handshake("hzb");
        issue("hzb_after", 3'd2, 3'd2, 2'b00, 0, 3'd0, 16'h0);
        check_eq("hzb_after_a", 32'(a_out), 32'hBEEF);
        check_eq("hzb_after_b", 32'(b_out), 32'hBEEF);
        handshake("hzb_after");

        // rn == rm with a write landing during READ_A
        issue("hza", 3'd6, 3'd6, 2'b10, 1, 3'd6, 16'h2222);
        check_eq("hza_a", 32'(a_out), BYPASS ? 32'h2222 : 32'h1111);
        check_eq("hza_b", 32'(b_out), 32'h2222);
        handshake("hza");

        // rn == rm without writes
        issue("same", 3'd4, 3'd4, 2'b00, 0, 3'd0, 16'h0);
        check_eq("same_a", 32'(a_out), 32'hAAAA);
        check_eq("same_b", 32'(b_out), 32'hAAAA);
        handshake("same");

        // Reset during READ_A together with a write to R1
        write_reg(3'd1, 16'h5555);
        rn = 3'd1; rm = 3'd1; shift_in = 2'b11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1; w_en = 1'b1; w_num = 3'd1; w_data = 16'h7777;
        @(negedge clk);
        reset = 1'b0; w_en = 1'b0;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_a", 32'(a_out), 32'h0);
        check_eq("mid_rst_b", 32'(b_out), 32'h0);
        check_eq("mid_rst_shift", 32'(shift_out), 32'h0);
        @(negedge clk);
        check_eq("mid_rst_no_valid", 32'(out_valid), 32'd0);
        issue("post_rst", 3'd1, 3'd3, 2'b01, 0, 3'd0, 16'h0);
        check_eq("post_rst_a", 32'(a_out), 32'h0000);
        check_eq("post_rst_b", 32'(b_out), 32'h0000);
        check_eq("post_rst_shift", 32'(shift_out), 32'h1);
        handshake("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
